// File: rtl/cpu_controller.sv
// Multi-cycle CPU sequencer: walks each instruction through eight phases and decodes datapath strobes.
// Optional build macro CTRL_HALT_RESUME_EN lets the resume input leave the HALT state.
module cpu_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  input  logic       resume,
  output logic [2:0] alu_op,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       data_e,
  output logic       wr,
  output logic       halt,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALT       = 4'd8
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t state;
  state_t next_state;
  logic   alu_class;

  // Instructions that read an operand from memory and write the accumulator
  assign alu_class = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
  assign phase = state;

`ifndef CTRL_HALT_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INST_ADDR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      INST_ADDR:  next_state = INST_FETCH;
      INST_FETCH: next_state = mem_rdy ? INST_LOAD : INST_FETCH;
      INST_LOAD:  next_state = IDLE;
      IDLE:       next_state = OP_ADDR;
      OP_ADDR:    next_state = (opcode == OP_HLT) ? HALT : OP_FETCH;
      // Operand fetch only waits on memory when a read is actually issued
      OP_FETCH:   next_state = (alu_class && !mem_rdy) ? OP_FETCH : ALU_OP;
      ALU_OP:     next_state = STORE;
      STORE:      next_state = INST_ADDR;
`ifdef CTRL_HALT_RESUME_EN
      HALT:       next_state = resume ? INST_ADDR : HALT;
`else
      HALT:       next_state = HALT;
`endif
      default:    next_state = INST_ADDR;
    endcase
  end

  always_comb begin
    alu_op = 3'b000;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;
    case (state)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        alu_op = opcode;
        inc_pc = 1'b1;
      end
      OP_FETCH: begin
        alu_op = opcode;
        rd     = alu_class;
      end
      // A taken SKZ is the second PC increment of the instruction
      ALU_OP: begin
        alu_op = opcode;
        rd     = alu_class;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      STORE: begin
        alu_op = opcode;
        rd     = alu_class;
        ld_ac  = alu_class;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
        wr     = (opcode == OP_STO);
      end
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have no parameters; opcode width is fixed at 3, matching the ALU opcode field.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 opcode  input  3  instruction opcode from IR: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
REQ-005 zero  input  1  ALU zero flag (SKZ_cmp), sampled only in ALU_OP.
REQ-006 mem_rdy  input  1  memory ready; a read completes in a cycle with rd=1 and mem_rdy=1.
REQ-007 resume  input  1  leave HALT (effective only under CTRL_HALT_RESUME_EN).
REQ-008 alu_op  output  3  equals opcode in OP_ADDR..STORE; 3'b000 in all other states.
REQ-009 sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt  output  1 each  datapath strobes (sel=PC drives address; else IR operand).
REQ-010 phase  output  4  current state encoding, for debug.

Function
REQ-011 FSM states and encodings SHALL be: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, HALT=8.
REQ-012 Nominal sequence SHALL be 0->1->2->3->4->5->6->7->0, one state per clock, 8 cycles per instruction with mem_rdy held 1.
REQ-013 INST_FETCH SHALL hold while mem_rdy=0 and advance to INST_LOAD on the first cycle mem_rdy=1.
REQ-014 OP_FETCH SHALL hold while rd=1 and mem_rdy=0; if rd=0 it SHALL advance unconditionally.
REQ-015 In OP_ADDR with opcode=HLT the next state SHALL be HALT instead of OP_FETCH.
REQ-016 Outputs SHALL be decoded combinationally from state and opcode; ALUOP means opcode in {ADD, AND, XOR, LDA}.
REQ-017 INST_ADDR: sel=1, all other strobes 0.
REQ-018 INST_FETCH: sel=1, rd=1.
REQ-019 INST_LOAD and IDLE: sel=1, rd=1, ld_ir=1.
REQ-020 OP_ADDR: inc_pc=1; all other strobes 0.
REQ-021 OP_FETCH: rd=ALUOP.
REQ-022 ALU_OP: rd=ALUOP; inc_pc=(opcode==SKZ && zero); ld_pc=(opcode==JMP); data_e=(opcode==STO).
REQ-023 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=(opcode==JMP); data_e=(opcode==STO); wr=(opcode==STO).
REQ-024 HALT: halt=1, all other strobes 0, alu_op=0; state SHALL remain HALT until reset (or resume, see Configuration).
REQ-025 wr SHALL never be asserted in the same cycle as rd; ld_pc and inc_pc SHALL never be asserted together.
REQ-026 SKZ with zero=0 SHALL produce no inc_pc in ALU_OP (one PC increment per instruction only).

Reset
REQ-027 rst_n=0 at a rising edge SHALL force state INST_ADDR from any state (including mid-instruction stall and HALT), taking priority over mem_rdy and resume.
REQ-028 In the cycle after reset: phase=0, sel=1, alu_op=0, every other strobe 0.

Configuration
REQ-029 Macro CTRL_HALT_RESUME_EN: when defined, resume=1 in HALT SHALL move to INST_ADDR on the next edge; when undefined, resume SHALL be ignored and HALT exits only via rst_n.

Verification
REQ-030 Reset then opcode=ADD, mem_rdy=1 -> phases 0..7 in 8 cycles; rd=1 in phases 1-3,5-7; ld_ac=1 only in phase 7; inc_pc=1 only in phase 4.
REQ-031 opcode=SKZ, zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 only in phase 4.
REQ-032 opcode=STO -> data_e=1 in phases 6,7; wr=1 only in phase 7; rd=0 in phases 5-7. opcode=JMP -> ld_pc=1 in phases 6,7.
REQ-033 mem_rdy=0 for 3 cycles entering phase 1 (opcode=LDA) -> phase stays 1 for 4 cycles with rd=1, then 2; same stall at phase 5.
REQ-034 opcode=HLT -> phase 4 then 8, halt=1 held 20 cycles; resume=1 -> returns to 0 only with CTRL_HALT_RESUME_EN; rst_n=0 -> 0 in both builds.
REQ-035 rst_n=0 asserted in phase 5 during mem_rdy stall -> next cycle phase=0, sel=1, rd=0.
